// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO accumulate unit: default half width,
// accumulate op encodings, accumulator word type and the sequencer states.
package hilo_pkg;

  localparam int HILO_DW = 32;

  localparam logic ACC_ADD = 1'b0;
  localparam logic ACC_SUB = 1'b1;

  typedef logic [2*HILO_DW-1:0] acc_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hilo_state_e;

  function automatic logic is_sub(input logic op);
    return op == ACC_SUB;
  endfunction

endpackage

// File: rtl/hilo_split_add.sv
// Combinational DW-bit adder with carry in/out; one instance per accumulate
// stage so the 2*DW-bit add is split across two cycles.
module hilo_split_add #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout
);

  logic [DW:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    sum  = full[DW-1:0];
    cout = full[DW];
  end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with per-half direct writes and a 2-stage cancellable
// MADD/MSUB accumulate path. Define HILO_BYPASS_EN to add hi_fwd/lo_fwd.
module hilo_acc_unit
  import hilo_pkg::*;
#(
  parameter int DW = HILO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_hi,
  input  logic          we_lo,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          acc_valid,
  input  logic          acc_sub,
  input  logic [2*DW-1:0] acc_i,
  output logic          acc_ready,
  input  logic          acc_flush,
  output logic          busy,
  output logic          acc_done,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
`ifdef HILO_BYPASS_EN
  ,
  output logic [DW-1:0] hi_fwd,
  output logic [DW-1:0] lo_fwd
`endif
);

  hilo_state_e   state_q, state_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          s1_sub_q, s1_sub_d;
  logic [DW:0]   s1_lo_sum_q, s1_lo_sum_d;
  logic [DW-1:0] s1_hi_op_q, s1_hi_op_d;
  logic          acc_done_q, acc_done_d;

  logic          direct_wr;
  logic          issue;
  logic          commit;
  logic          sub_op;
  logic [DW-1:0] op_lo;
  logic [DW-1:0] op_hi;
  logic [DW-1:0] lo_sum;
  logic          lo_cout;
  logic [DW-1:0] hi_sum;
  logic          hi_cout;
  logic          unused_ok;

  assign busy      = (state_q == ST_BUSY);
  assign direct_wr = we_hi | we_lo;
  assign acc_ready = ~busy & ~direct_wr & ~acc_flush;
  assign issue     = acc_valid & acc_ready;
  assign commit    = busy & ~acc_flush & ~direct_wr;

  // Subtraction is two's complement: invert the operand, inject +1 at the LO carry-in.
  assign sub_op = is_sub(acc_sub);
  assign op_lo  = sub_op ? ~acc_i[DW-1:0]    : acc_i[DW-1:0];
  assign op_hi  = sub_op ? ~acc_i[2*DW-1:DW] : acc_i[2*DW-1:DW];

  hilo_split_add #(.DW(DW)) u_add_lo (
    .a    (lo_q),
    .b    (op_lo),
    .cin  (sub_op),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  hilo_split_add #(.DW(DW)) u_add_hi (
    .a    (hi_q),
    .b    (s1_hi_op_q),
    .cin  (s1_lo_sum_q[DW]),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Result wraps modulo 2^(2*DW); the final carry and stored op are not needed downstream.
  assign unused_ok = ^{hi_cout, s1_sub_q};

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    s1_sub_d    = s1_sub_q;
    s1_lo_sum_d = s1_lo_sum_q;
    s1_hi_op_d  = s1_hi_op_q;
    acc_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d     = ST_BUSY;
          s1_sub_d    = acc_sub;
          s1_lo_sum_d = {lo_cout, lo_sum};
          s1_hi_op_d  = op_hi;
        end
      end
      ST_BUSY: begin
        state_d = ST_IDLE;
        if (commit) begin
          hi_d       = hi_sum;
          lo_d       = s1_lo_sum_q[DW-1:0];
          acc_done_d = 1'b1;
        end
      end
    endcase

    // A direct write is younger than any in-flight accumulate and always wins.
    if (we_hi) hi_d = hi_i;
    if (we_lo) lo_d = lo_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      s1_sub_q    <= ACC_ADD;
      s1_lo_sum_q <= '0;
      s1_hi_op_q  <= '0;
      acc_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      s1_sub_q    <= s1_sub_d;
      s1_lo_sum_q <= s1_lo_sum_d;
      s1_hi_op_q  <= s1_hi_op_d;
      acc_done_q  <= acc_done_d;
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign acc_done = acc_done_q;

`ifdef HILO_BYPASS_EN
  // Only pending direct writes are forwarded; accumulate results are not.
  assign hi_fwd = we_hi ? hi_i : hi_q;
  assign lo_fwd = we_lo ? lo_i : lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboard bench for hilo_acc_unit: a 2*DW-bit reference model pushes the
// expected post-edge state per driven cycle; it is popped and compared after the edge.
module tb_hilo_acc_unit;
  import hilo_pkg::*;

  localparam int DW = HILO_DW;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          busy;
    logic          done;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            we_hi, we_lo;
  logic [DW-1:0]   hi_i, lo_i;
  logic            acc_valid, acc_sub, acc_flush;
  logic [2*DW-1:0] acc_i;
  logic            acc_ready, busy, acc_done;
  logic [DW-1:0]   hi_o, lo_o;
`ifdef HILO_BYPASS_EN
  logic [DW-1:0]   hi_fwd, lo_fwd;
`endif

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mdl_hi, mdl_lo;
  logic          mdl_busy;
  acc_word_t     mdl_target;

  always #5 clk = ~clk;

  hilo_acc_unit #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .we_hi     (we_hi),
    .we_lo     (we_lo),
    .hi_i      (hi_i),
    .lo_i      (lo_i),
    .acc_valid (acc_valid),
    .acc_sub   (acc_sub),
    .acc_i     (acc_i),
    .acc_ready (acc_ready),
    .acc_flush (acc_flush),
    .busy      (busy),
    .acc_done  (acc_done),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
`ifdef HILO_BYPASS_EN
    ,
    .hi_fwd    (hi_fwd),
    .lo_fwd    (lo_fwd)
`endif
  );

  task automatic checkOutput(input string tag, input logic [2*DW-1:0] got,
                             input logic [2*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setIdle();
    we_hi = 1'b0; we_lo = 1'b0; hi_i = '0; lo_i = '0;
    acc_valid = 1'b0; acc_sub = ACC_ADD; acc_i = '0; acc_flush = 1'b0;
  endtask

  task automatic popAndCompare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, ".queue_empty"}, 64'(1), 64'(0));
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, ".hi"},   64'(hi_o),     64'(e.hi));
    checkOutput({tag, ".lo"},   64'(lo_o),     64'(e.lo));
    checkOutput({tag, ".busy"}, 64'(busy),     64'(e.busy));
    checkOutput({tag, ".done"}, 64'(acc_done), 64'(e.done));
  endtask

  // One cycle of stimulus: drive at negedge, model the edge, compare after it.
  task automatic applyStimulus(input string tag, input logic whi, input logic wlo,
                               input logic [DW-1:0] hin, input logic [DW-1:0] lin,
                               input logic v, input logic sb, input acc_word_t a,
                               input logic fl);
    exp_t      e;
    logic      rdy;
    logic      new_busy;
    acc_word_t cur;
    @(negedge clk);
    we_hi = whi; we_lo = wlo; hi_i = hin; lo_i = lin;
    acc_valid = v; acc_sub = sb; acc_i = a; acc_flush = fl;
    #1;
    rdy = !mdl_busy && !whi && !wlo && !fl;
    checkOutput({tag, ".ready"}, 64'(acc_ready), 64'(rdy));
`ifdef HILO_BYPASS_EN
    checkOutput({tag, ".hi_fwd"}, 64'(hi_fwd), 64'(whi ? hin : mdl_hi));
    checkOutput({tag, ".lo_fwd"}, 64'(lo_fwd), 64'(wlo ? lin : mdl_lo));
    checkOutput({tag, ".hi_pre"}, 64'(hi_o), 64'(mdl_hi));
`endif
    cur    = {mdl_hi, mdl_lo};
    e.done = 1'b0;
    if (mdl_busy && !fl && !whi && !wlo) begin
      {mdl_hi, mdl_lo} = mdl_target;
      e.done = 1'b1;
    end
    new_busy = v && rdy;
    if (new_busy) mdl_target = sb ? cur - a : cur + a;
    if (whi) mdl_hi = hin;
    if (wlo) mdl_lo = lin;
    mdl_busy = new_busy;
    e.hi   = mdl_hi;
    e.lo   = mdl_lo;
    e.busy = mdl_busy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    popAndCompare(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, '0, '0, 1'b0, ACC_ADD, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] r_hi, r_lo, r_a0, r_a1;
    logic          r_whi, r_wlo, r_v, r_sb, r_fl;

    setIdle();
    mdl_hi = '0; mdl_lo = '0; mdl_busy = 1'b0; mdl_target = '0;
    #12;
    checkOutput("rst.hi",   64'(hi_o),     64'(0));
    checkOutput("rst.lo",   64'(lo_o),     64'(0));
    checkOutput("rst.busy", 64'(busy),     64'(0));
    checkOutput("rst.done", 64'(acc_done), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset while an accumulate is in flight.
    applyStimulus("t1.load", 1'b1, 1'b1, 32'h5, 32'h7, 1'b0, ACC_ADD, '0, 1'b0);
    applyStimulus("t1.issue", 1'b0, 1'b0, '0, '0, 1'b1, ACC_ADD, 64'h3, 1'b0);
    setIdle();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t1.async.hi",   64'(hi_o),     64'(0));
    checkOutput("t1.async.lo",   64'(lo_o),     64'(0));
    checkOutput("t1.async.busy", 64'(busy),     64'(0));
    @(posedge clk);
    #1;
    checkOutput("t1.held.done", 64'(acc_done), 64'(0));
    checkOutput("t1.held.busy", 64'(busy),     64'(0));
    @(negedge clk);
    rst = 1'b1;
    mdl_hi = '0; mdl_lo = '0; mdl_busy = 1'b0;
    idleCycle("t1.after");

    // Independent half writes.
    applyStimulus("t2.whi", 1'b1, 1'b0, 32'hAAAA0000, 32'hDEAD, 1'b0, ACC_ADD, '0, 1'b0);
    applyStimulus("t2.wlo", 1'b0, 1'b1, 32'hBEEF, 32'h00001234, 1'b0, ACC_ADD, '0, 1'b0);

    // Add with carry out of LO.
    applyStimulus("t3.load", 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, ACC_ADD, '0, 1'b0);
    applyStimulus("t3.issue", 1'b0, 1'b0, '0, '0, 1'b1, ACC_ADD, 64'h1, 1'b0);
    idleCycle("t3.commit");
    idleCycle("t3.after");

    // Subtract with borrow through both halves.
    applyStimulus("t4.load", 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, ACC_ADD, '0, 1'b0);
    applyStimulus("t4.issue", 1'b0, 1'b0, '0, '0, 1'b1, ACC_SUB, 64'h1, 1'b0);
    idleCycle("t4.commit");

    // Cancellation by a direct write and by a flush.
    applyStimulus("t5.load", 1'b1, 1'b1, 32'h11, 32'h22, 1'b0, ACC_ADD, '0, 1'b0);
    applyStimulus("t5.issue", 1'b0, 1'b0, '0, '0, 1'b1, ACC_ADD, 64'h1_00000005, 1'b0);
    applyStimulus("t5.whi", 1'b1, 1'b0, 32'hA, '0, 1'b0, ACC_ADD, '0, 1'b0);
    idleCycle("t5.quiet1");
    applyStimulus("t5.issue2", 1'b0, 1'b0, '0, '0, 1'b1, ACC_SUB, 64'h7_00000009, 1'b0);
    applyStimulus("t5.flush", 1'b0, 1'b0, '0, '0, 1'b0, ACC_ADD, '0, 1'b1);
    idleCycle("t5.quiet2");
    applyStimulus("t5.collide", 1'b0, 1'b1, '0, 32'h99, 1'b1, ACC_ADD, 64'h5, 1'b0);
    applyStimulus("t5.flush_issue", 1'b0, 1'b0, '0, '0, 1'b1, ACC_ADD, 64'h5, 1'b1);
    applyStimulus("t5.issue3", 1'b0, 1'b0, '0, '0, 1'b1, ACC_ADD, 64'h2_80000000, 1'b0);
    applyStimulus("t5.drop", 1'b0, 1'b0, '0, '0, 1'b1, ACC_SUB, 64'hFFFF, 1'b0);
    idleCycle("t5.after");

    // Same-cycle visibility of a pending HI write.
    applyStimulus("t6.fwd", 1'b1, 1'b0, 32'h55, '0, 1'b0, ACC_ADD, '0, 1'b0);
    idleCycle("t6.nofwd");

    // Random mix of writes, accumulates and flushes.
    for (int i = 0; i < 40; i++) begin
      r_hi  = $urandom;
      r_lo  = $urandom;
      r_a0  = $urandom;
      r_a1  = $urandom;
      r_whi = ($urandom_range(0, 5) == 0);
      r_wlo = ($urandom_range(0, 5) == 0);
      r_v   = ($urandom_range(0, 2) != 0);
      r_sb  = $urandom_range(0, 1) == 1;
      r_fl  = ($urandom_range(0, 7) == 0);
      applyStimulus("rnd", r_whi, r_wlo, r_hi, r_lo, r_v, r_sb, {r_a1, r_a0}, r_fl);
    end
    idleCycle("rnd.drain");

    setIdle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
